pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Sequencer for the far end of the clock-generator reset/lock interface.
- Drives the PLL `rst` input and consumes the PLL `locked` output.
- Releases a qualified miner-core reset only after lock has been held stable.
- Sits in the reference-clock domain beside the PLL wrapper. Re-sequences the PLL on lock loss or on request; declares a fault after repeated failed lock attempts.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (min 1).
- LOCK_TIMEOUT, 50000: max cycles in WAIT_LOCK before an attempt counts as failed (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive locked cycles required before the core reset is released.
- MAX_RETRIES, 4: failed attempts allowed before FAULT (min 1).

Ports:
- clk  in  1  reference clock, the same clock feeding the PLL refclk
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL locked output; asynchronous to clk
- force_relock  in  1  single-cycle request to re-sequence the PLL
- pll_rst  out  1  to PLL rst
- sys_reset  out  1  active-high reset for downstream logic; the consumer synchronizes it into the PLL output domain
- ready  out  1  high in RUN
- fault  out  1  high in FAULT
- attempt  out  3  attempts used in the current sequence
- lock_loss_cnt  out  8  saturating count of lock losses seen in RUN

Behaviour:
- Input sync: `pll_locked` passes through a 2-flop synchronizer (`lk_s`). Synchronizer flops reset to 0.
- Reset values: pll_rst=1, sys_reset=1, ready=0, fault=0, attempt=0, lock_loss_cnt=0, timer=0, state=PLL_RST.
- Reset mid-operation returns to these values on the next edge from any state. lock_loss_cnt is cleared only by `reset`.
- All outputs are registered; no combinational paths from inputs to outputs.
- Timer width is the clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. It is cleared on every state change.

States:
- PLL_RST: pll_rst=1, sys_reset=1. When timer reaches RST_CYCLES-1, go to WAIT_LOCK and set attempt = attempt+1. pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, sys_reset=1.
  - lk_s=1 -> go to STABLE.
  - Timer reaches LOCK_TIMEOUT-1 with lk_s=0: if attempt == MAX_RETRIES go to FAULT, else go to PLL_RST.
- STABLE: pll_rst=0, sys_reset=1.
  - lk_s=0 -> go to WAIT_LOCK. The timer restarts; attempt is unchanged because this is a glitch, not a new attempt.
  - Timer reaches STABLE_CYCLES-1 with lk_s=1 -> go to RUN and set attempt=0.
- RUN: sys_reset=0, ready=1.
  - lk_s=0 -> go to PLL_RST, assert sys_reset and pll_rst on the next edge, and increment lock_loss_cnt (saturates at 255).
- FAULT: pll_rst=1, sys_reset=1, fault=1. The state is sticky; only `reset` or `force_relock` leaves it.
- force_relock: in any state, go to PLL_RST with attempt=0 and timer=0.
  - It has priority over all other transitions in the same cycle.
  - In RUN it does not increment lock_loss_cnt.
  - Asserted while already in PLL_RST, it restarts the reset pulse.
- Simultaneous events in RUN, lock loss with force_relock: one PLL_RST entry, counter not incremented.

Latency:
- From `reset` deassertion to sys_reset falling, with locked high throughout: RST_CYCLES + (cycles for lk_s to reach 1) + STABLE_CYCLES.
- From pll_locked falling in RUN to sys_reset high: 3 edges (2 sync + 1 registered).

Decomposition:
- Shared package: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT) and the timer-width function.
- One sub-module, sync_2ff (parameterized width, reset value 0), reused for other asynchronous status inputs elsewhere in the design.

Test Plan:
- Params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2; locked tied to 1 after reset -> pll_rst high exactly 4 cycles, ready rises RST+2+8 cycles later, attempt returns to 0.
- locked stuck 0 -> two 4-cycle pll_rst pulses, each followed by 20-cycle waits, then fault=1 with pll_rst=1 and attempt=2; force_relock pulse -> fault=0 and a new 4-cycle pll_rst pulse.
- In RUN, drop locked for 1 cycle -> sys_reset high within 3 edges, lock_loss_cnt=1, full re-sequence back to RUN.
- In STABLE, drop locked at stable timer=5 -> returns to WAIT_LOCK, attempt unchanged, STABLE then restarts and needs a full 8 cycles.
- 300 lock losses in RUN -> lock_loss_cnt saturates at 255.
- Assert reset during WAIT_LOCK, and force_relock coincident with lock loss in RUN -> all outputs at reset values / single PLL_RST entry with counter unchanged.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    // Width of a timer that must reach the largest of three cycle counts,
    // with one bit of headroom.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; both stages reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages give a metastable first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Drives the PLL reset, waits for a stable lock, then releases the core reset.
// Re-sequences on lock loss or on force_relock; enters a sticky FAULT after
// MAX_RETRIES lock attempts time out. All outputs are registered.
// The current FSM state is visible as the signal `state` for checkers.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [2:0] attempt,
    output logic [7:0] lock_loss_cnt
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);

    seq_state_t    state;
    logic [TW-1:0] timer;
    logic          lk_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PLL_RST;
            timer         <= '0;
            attempt       <= 3'd0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else if (force_relock) begin
            // Wins over every other transition; never counts as a lock loss.
            state     <= PLL_RST;
            timer     <= '0;
            attempt   <= 3'd0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        attempt <= attempt + 3'd1;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state <= STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (attempt == RETRY_LIMIT) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= PLL_RST;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        // Lock glitch: keep the same attempt, restart the wait.
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state     <= RUN;
                        timer     <= '0;
                        attempt   <= 3'd0;
                        sys_reset <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state     <= PLL_RST;
                        timer     <= '0;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    // Sticky until reset or force_relock.
                    timer <= '0;
                end
                default: begin
                    state     <= PLL_RST;
                    timer     <= '0;
                    attempt   <= 3'd0;
                    pll_rst   <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: a behavioural model predicts the outputs after
// every clock edge into a queue; a monitor pops and compares each cycle.
module tb_pll_reset_seq;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int ST_C  = 8;
    localparam int MR_C  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic pll_locked;
    logic force_relock;
    logic pll_rst;
    logic sys_reset;
    logic ready;
    logic fault;
    logic [2:0] attempt;
    logic [7:0] lock_loss_cnt;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C),
        .MAX_RETRIES   (MR_C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .sys_reset     (sys_reset),
        .ready         (ready),
        .fault         (fault),
        .attempt       (attempt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Phases of the sequence; m_left counts cycles still to spend in the
    // current timed phase before its deadline is reached.
    localparam int M_RST   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    int   m_phase = M_RST;
    int   m_left  = RST_C;
    int   m_att   = 0;
    int   m_loss  = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    bit   m_valid = 1'b0;

    logic [14:0] exp_q[$];

    function automatic logic [14:0] model_outputs();
        logic e_rst, e_sys, e_rdy, e_flt;
        e_rst = (m_phase == M_RST) || (m_phase == M_FAULT);
        e_sys = (m_phase != M_RUN);
        e_rdy = (m_phase == M_RUN);
        e_flt = (m_phase == M_FAULT);
        return {e_rst, e_sys, e_rdy, e_flt, 3'(m_att), 8'(m_loss)};
    endfunction

    // Advance the model on each edge from the inputs the bench drove.
    always @(posedge clk) begin
        logic lk;
        lk = m_s2;
        if (reset === 1'b1) begin
            m_phase = M_RST;
            m_left  = RST_C;
            m_att   = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (force_relock === 1'b1) begin
                m_phase = M_RST;
                m_left  = RST_C;
                m_att   = 0;
            end else begin
                case (m_phase)
                    M_RST: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = M_WAIT;
                            m_left  = TO_C;
                            m_att++;
                        end
                    end
                    M_WAIT: begin
                        m_left--;
                        if (lk) begin
                            m_phase = M_STAB;
                            m_left  = ST_C;
                        end else if (m_left == 0) begin
                            if (m_att == MR_C) m_phase = M_FAULT;
                            else begin
                                m_phase = M_RST;
                                m_left  = RST_C;
                            end
                        end
                    end
                    M_STAB: begin
                        m_left--;
                        if (!lk) begin
                            m_phase = M_WAIT;
                            m_left  = TO_C;
                        end else if (m_left == 0) begin
                            m_phase = M_RUN;
                            m_att   = 0;
                        end
                    end
                    M_RUN: begin
                        if (!lk) begin
                            m_phase = M_RST;
                            m_left  = RST_C;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: ;
                endcase
            end
            m_s2 = m_s1;
            m_s1 = pll_locked;
        end
        if (m_valid) exp_q.push_back(model_outputs());
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [14:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, sys_reset, ready, fault, attempt, lock_loss_cnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t: got rst=%b sys=%b rdy=%b flt=%b att=%0d loss=%0d, expected rst=%b sys=%b rdy=%b flt=%b att=%0d loss=%0d",
                         $time, a[14], a[13], a[12], a[11], a[10:8], a[7:0],
                         e[14], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s: ready=%b after %0d cycles, expected 1", name, ready, n);
        end
    endtask

    task automatic wait_fault(input string name, input int budget);
        int n;
        n = 0;
        while (fault !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL %s: fault=%b after %0d cycles, expected 1", name, fault, n);
        end
    endtask

    // Width of the pll_rst pulse starting at the current sample.
    task automatic measure_rst_pulse(input string name);
        int w;
        w = 0;
        while (pll_rst === 1'b1 && w < 40) begin
            w++;
            @(negedge clk);
        end
        check(name, w, RST_C);
    endtask

    task automatic wait_model(input int phase, input int left, input int budget);
        int n;
        n = 0;
        while (!(m_phase == phase && m_left == left) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("model_phase_reached", int'(m_phase == phase && m_left == left), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sys_edges;
        reset        = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        step(3);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_reset", int'(sys_reset), 1);
        check("reset_attempt", int'(attempt), 0);

        // Locked high from release: one clean pulse then RUN.
        reset      = 1'b0;
        pll_locked = 1'b1;
        measure_rst_pulse("first_pulse_width");
        wait_ready("first_ready", 100);
        check("run_attempt_zero", int'(attempt), 0);

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0;
        sys_edges  = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            pll_locked = 1'b1;
            if (sys_reset === 1'b1 && sys_edges == 0) sys_edges = k;
        end
        check("loss_to_sys_reset_edges", sys_edges, 3);
        check("loss_count_one", int'(lock_loss_cnt), 1);
        wait_ready("ready_after_loss", 100);

        // Lock never comes: two attempts then FAULT, then recover by force.
        pll_locked   = 1'b0;
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        wait_fault("fault_reached", 200);
        check("fault_attempt", int'(attempt), MR_C);
        check("fault_pll_rst", int'(pll_rst), 1);
        step(5);
        check("fault_sticky", int'(fault), 1);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check("fault_cleared", int'(fault), 0);
        measure_rst_pulse("relock_pulse_width");
        pll_locked = 1'b1;
        wait_ready("ready_after_fault", 100);

        // Glitch while STABLE: lk_s seen low at stable timer 5.
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        wait_model(M_STAB, ST_C - 3, 50);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(3);
        check("glitch_attempt_kept", int'(attempt), 1);
        wait_ready("ready_after_glitch", 100);

        // Many lock losses: counter saturates.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            step(3);
            wait_ready("ready_in_loss_loop", 100);
        end
        check("loss_saturated", int'(lock_loss_cnt), 255);

        // Reset while waiting for lock.
        pll_locked   = 1'b0;
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        wait_model(M_WAIT, TO_C - 3, 50);
        reset = 1'b1;
        step(1);
        check("midreset_pll_rst", int'(pll_rst), 1);
        check("midreset_fault", int'(fault), 0);
        check("midreset_loss", int'(lock_loss_cnt), 0);
        check("midreset_attempt", int'(attempt), 0);
        reset      = 1'b0;
        pll_locked = 1'b1;
        wait_ready("ready_after_midreset", 100);

        // Force coincident with lock loss in RUN.
        pll_locked = 1'b0;
        step(2);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        pll_locked   = 1'b1;
        check("coincident_pll_rst", int'(pll_rst), 1);
        check("coincident_loss_kept", int'(lock_loss_cnt), 0);
        wait_ready("ready_after_coincident", 100);

        // Random traffic: mostly locked, then mostly unlocked.
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) pll_locked = ($urandom_range(0, 19) != 0);
            else          pll_locked = ($urandom_range(0, 9) < 3);
            force_relock = ($urandom_range(0, 199) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset        = 1'b0;
        force_relock = 1'b0;
        pll_locked   = 1'b1;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
